// File: rtl/eye_pkg.sv
`default_nettype none
// eye_pkg: shared widths and reset levels for the eye-diagram test-signal generator.
package eye_pkg;

  localparam int SPEED_W = 4;
  localparam int CNT_W   = 4;

  localparam logic SIG_RST   = 1'b0;
  localparam logic OUT_P_RST = 1'b0;
  localparam logic OUT_N_RST = 1'b1;

endpackage
`default_nettype wire

// File: rtl/sq_wave_divider.sv
`default_nettype none
// sq_wave_divider: synchronised speed select driving a 50 % square wave,
// half period = speed + 1 clocks, speed changes applied only at period ends.
module sq_wave_divider
  import eye_pkg::*;
#(
  parameter int SPEED_W = eye_pkg::SPEED_W,
  parameter int CNT_W   = eye_pkg::CNT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [SPEED_W-1:0] speed,
  output logic               out_p,
  output logic               out_n
);

  logic [SPEED_W-1:0] sync1_q;
  logic [SPEED_W-1:0] sync2_q;
  logic [SPEED_W-1:0] spd_act_q;
  logic [SPEED_W-1:0] spd_act_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   cnt_d;
  logic               sig_q;
  logic               sig_d;
  logic               out_p_q;
  logic               out_n_q;
  logic               half_end;

  // Synchroniser is deliberately unreset; reset is long enough to flush it.
  always_ff @(posedge clk) begin
    sync1_q <= speed;
    sync2_q <= sync1_q;
  end

  always_comb begin
    half_end  = (cnt_q == CNT_W'(spd_act_q));
    cnt_d     = cnt_q + CNT_W'(1);
    sig_d     = sig_q;
    spd_act_d = spd_act_q;
    if (half_end) begin
      cnt_d = '0;
      sig_d = ~sig_q;
      // A period ends when the high phase ends; only then may the speed change.
      if (sig_q) begin
        spd_act_d = sync2_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      sig_q     <= SIG_RST;
      spd_act_q <= sync2_q;
      out_p_q   <= OUT_P_RST;
      out_n_q   <= OUT_N_RST;
    end else begin
      cnt_q     <= cnt_d;
      sig_q     <= sig_d;
      spd_act_q <= spd_act_d;
      out_p_q   <= sig_d;
      out_n_q   <= ~sig_d;
    end
  end

  assign out_p = out_p_q;
  assign out_n = out_n_q;

endmodule
`default_nettype wire

// File: rtl/eye_test_signal_top.sv
`default_nettype none
// eye_test_signal_top: board-level wrapper; differential clock in,
// differential square wave out at 200 MHz / (2 * (SPEEDCTR + 1)).
module eye_test_signal_top
  import eye_pkg::*;
#(
  parameter int SPEED_W = eye_pkg::SPEED_W,
  parameter int CNT_W   = eye_pkg::CNT_W
) (
  input  logic               SYSCLK_P,
  input  logic               SYSCLK_N,
  input  logic               G_RST,
  input  logic [SPEED_W-1:0] SPEEDCTR,
  output logic               signal_output_p,
  output logic               signal_output_n
);

  logic clk;
  logic unused_sysclk_n;
  logic div_p;
  logic div_n;

  // Differential clock input buffer model: the N leg only matters to the pad.
  assign clk             = SYSCLK_P;
  assign unused_sysclk_n = SYSCLK_N;

  sq_wave_divider #(
    .SPEED_W (SPEED_W),
    .CNT_W   (CNT_W)
  ) u_div (
    .clk   (clk),
    .rst   (G_RST),
    .speed (SPEEDCTR),
    .out_p (div_p),
    .out_n (div_n)
  );

  // Differential output buffer model: legs come straight from matched flops.
  assign signal_output_p = div_p;
  assign signal_output_n = div_n;

endmodule
`default_nettype wire

// File: tb/tb_eye_test_signal_top.sv
`timescale 1ns/1ps
`default_nettype none
// Directed bench for eye_test_signal_top: widths, first-rise latency and leg complementarity.
module tb_eye_test_signal_top;

  logic       SYSCLK_P;
  logic       SYSCLK_N;
  logic       G_RST;
  logic [3:0] SPEEDCTR;
  logic       signal_output_p;
  logic       signal_output_n;

  int vectors;
  int miscompares;

  eye_test_signal_top dut (
    .SYSCLK_P        (SYSCLK_P),
    .SYSCLK_N        (SYSCLK_N),
    .G_RST           (G_RST),
    .SPEEDCTR        (SPEEDCTR),
    .signal_output_p (signal_output_p),
    .signal_output_n (signal_output_n)
  );

  initial begin
    SYSCLK_P = 1'b0;
    forever #2.5 SYSCLK_P = ~SYSCLK_P;
  end
  assign SYSCLK_N = ~SYSCLK_P;

  task automatic tick;
    @(posedge SYSCLK_P);
    #1;
  endtask

  task automatic do_reset(input int n);
    G_RST = 1'b1;
    repeat (n) tick();
    G_RST = 1'b0;
  endtask

  // Cycles until p is seen high, counting the first post-release edge as 1.
  task automatic wait_rise(output int cyc, output bit timeout);
    cyc = 0;
    timeout = 1'b0;
    do begin
      tick();
      cyc++;
    end while (signal_output_p !== 1'b1 && cyc < 100);
    if (signal_output_p !== 1'b1) timeout = 1'b1;
  endtask

  // Starts on a high sample; returns high/low widths and ends on the next high sample.
  task automatic measure_period(output int hi, output int lo, output int leg_bad);
    hi = 0;
    lo = 0;
    leg_bad = 0;
    while (signal_output_p === 1'b1 && hi < 100) begin
      if (signal_output_p === signal_output_n) leg_bad++;
      hi++;
      tick();
    end
    while (signal_output_p === 1'b0 && lo < 100) begin
      if (signal_output_p === signal_output_n) leg_bad++;
      lo++;
      tick();
    end
  endtask

  task automatic test_reset;
    int  cyc, hi, lo, bad, rst_bad;
    bit  to;
    SPEEDCTR = 4'd5;
    G_RST    = 1'b1;
    rst_bad  = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (i >= 1 && (signal_output_p !== 1'b0 || signal_output_n !== 1'b1)) rst_bad++;
    end
    vectors++;
    if (rst_bad !== 0) begin
      miscompares++;
      $display("FAIL reset_levels: %0d bad cycles, required 0", rst_bad);
    end
    G_RST = 1'b0;
    wait_rise(cyc, to);
    vectors++;
    if (to || cyc !== 6) begin
      miscompares++;
      $display("FAIL reset_first_rise: got %0d cycles (timeout=%0d), required 6", cyc, to);
    end
    for (int k = 0; k < 2; k++) begin
      measure_period(hi, lo, bad);
      vectors++;
      if (hi !== 6 || lo !== 6 || bad !== 0) begin
        miscompares++;
        $display("FAIL spd5_period%0d: hi=%0d lo=%0d legbad=%0d, required 6/6/0", k, hi, lo, bad);
      end
    end
  endtask

  task automatic test_max_speed;
    int cyc, hi, lo, bad;
    bit to;
    SPEEDCTR = 4'd0;
    do_reset(4);
    wait_rise(cyc, to);
    vectors++;
    if (to || cyc !== 1) begin
      miscompares++;
      $display("FAIL max_first_rise: got %0d (timeout=%0d), required 1", cyc, to);
    end
    for (int k = 0; k < 3; k++) begin
      measure_period(hi, lo, bad);
      vectors++;
      if (hi !== 1 || lo !== 1 || bad !== 0) begin
        miscompares++;
        $display("FAIL max_period%0d: hi=%0d lo=%0d legbad=%0d, required 1/1/0", k, hi, lo, bad);
      end
    end
  endtask

  task automatic test_min_speed;
    int cyc, hi, lo, bad;
    bit to;
    SPEEDCTR = 4'd15;
    do_reset(4);
    wait_rise(cyc, to);
    vectors++;
    if (to || cyc !== 16) begin
      miscompares++;
      $display("FAIL min_first_rise: got %0d (timeout=%0d), required 16", cyc, to);
    end
    measure_period(hi, lo, bad);
    vectors++;
    if (hi !== 16 || lo !== 16 || bad !== 0) begin
      miscompares++;
      $display("FAIL min_period: hi=%0d lo=%0d legbad=%0d, required 16/16/0", hi, lo, bad);
    end
  endtask

  task automatic test_change_running;
    int cyc, hi, lo, bad;
    bit to;
    SPEEDCTR = 4'd5;
    do_reset(4);
    wait_rise(cyc, to);
    tick();
    tick();
    SPEEDCTR = 4'd2;
    // Two high samples already seen; the rest of this high stays at old speed.
    measure_period(hi, lo, bad);
    vectors++;
    if (hi !== 4 || lo !== 3 || bad !== 0) begin
      miscompares++;
      $display("FAIL change_boundary: hi=%0d lo=%0d legbad=%0d, required 4/3/0", hi, lo, bad);
    end
    for (int k = 0; k < 2; k++) begin
      measure_period(hi, lo, bad);
      vectors++;
      if (hi !== 3 || lo !== 3 || bad !== 0) begin
        miscompares++;
        $display("FAIL change_after%0d: hi=%0d lo=%0d legbad=%0d, required 3/3/0", k, hi, lo, bad);
      end
    end
  endtask

  task automatic test_reset_mid;
    int cyc, hi, lo, bad;
    bit to;
    SPEEDCTR = 4'd5;
    do_reset(4);
    wait_rise(cyc, to);
    tick();
    G_RST = 1'b1;
    tick();
    vectors++;
    if (signal_output_p !== 1'b0 || signal_output_n !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_reset_levels: p=%b n=%b, required p=0 n=1", signal_output_p, signal_output_n);
    end
    tick();
    tick();
    G_RST = 1'b0;
    wait_rise(cyc, to);
    vectors++;
    if (to || cyc !== 6) begin
      miscompares++;
      $display("FAIL mid_reset_first_rise: got %0d (timeout=%0d), required 6", cyc, to);
    end
    measure_period(hi, lo, bad);
    vectors++;
    if (hi !== 6 || lo !== 6 || bad !== 0) begin
      miscompares++;
      $display("FAIL mid_reset_period: hi=%0d lo=%0d legbad=%0d, required 6/6/0", hi, lo, bad);
    end
  endtask

  task automatic test_sweep;
    int hi, lo, bad, exp_w;
    for (int s = 0; s < 16; s++) begin
      SPEEDCTR = 4'(s);
      exp_w = s + 1;
      measure_period(hi, lo, bad);
      measure_period(hi, lo, bad);
      for (int k = 0; k < 2; k++) begin
        measure_period(hi, lo, bad);
        vectors++;
        if (hi !== exp_w || lo !== exp_w || bad !== 0) begin
          miscompares++;
          $display("FAIL sweep_s%0d_p%0d: hi=%0d lo=%0d legbad=%0d, required %0d/%0d/0",
                   s, k, hi, lo, bad, exp_w, exp_w);
        end
      end
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    G_RST       = 1'b1;
    SPEEDCTR    = 4'd5;
    test_reset();
    test_max_speed();
    test_min_speed();
    test_change_running();
    test_reset_mid();
    test_sweep();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
